sram_like_slave: RTL and testbench
==================================

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word-address bits of the backing RAM (64 KiB).
REQ-002 SHALL have parameter ADDR_DELAY, default 0, cycles req must be held in IDLE before addr_ok asserts (0..15).
REQ-003 SHALL have parameter RESP_DELAY, default 0, extra cycles between RAM read and data_ok (0..15).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  1  master request valid.
REQ-007 wr  in  1  1 = write, 0 = read.
REQ-008 size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  write data, lane-aligned to addr[1:0].
REQ-011 addr_ok  out  1  request accepted this cycle.
REQ-012 data_ok  out  1  one-cycle response pulse; read data valid; write complete.
REQ-013 rdata  out  32  full unshifted RAM word, valid only while data_ok=1.
REQ-014 ram_en  out  1  synchronous RAM access enable.
REQ-015 ram_we  out  4  byte write strobes.
REQ-016 ram_addr  out  ADDR_WIDTH  word address = addr[ADDR_WIDTH+1:2].
REQ-017 ram_wdata  out  32  equals wdata.
REQ-018 ram_rdata  in  32  RAM read data, valid the cycle after an ram_en=1 edge.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, RESP; only one transaction outstanding at any time.
REQ-020 IDLE: wait counter increments each cycle req=1 and counter<ADDR_DELAY; clears to 0 whenever req=0.
REQ-021 addr_ok SHALL be combinational: 1 iff state=IDLE, req=1, counter=ADDR_DELAY; handshake = addr_ok&req at a rising edge.
REQ-022 In the handshake cycle ram_en=1, ram_addr/ram_wdata driven from current inputs, ram_we=0000 for reads; ram_en=0 and ram_we=0000 in all other cycles.
REQ-023 Write strobes: size 0 -> 0001<<addr[1:0]; size 1 -> addr[1]?1100:0011 (addr[0] ignored); size 2/3 -> 1111 (addr[1:0] ignored).
REQ-024 On handshake: counter cleared; next state RESP if RESP_DELAY=0, else WAIT with delay counter loaded to RESP_DELAY.
REQ-025 First cycle after handshake: rdata_q SHALL capture ram_rdata at its end edge (reads and writes alike).
REQ-026 WAIT: delay counter decrements each cycle; at 1 -> RESP next edge.
REQ-027 RESP: data_ok=1 for exactly one cycle, then IDLE; addr_ok=0 in WAIT and RESP (req held high is ignored there).
REQ-028 rdata = ram_rdata when in RESP and it is the first cycle after handshake (RESP_DELAY=0), else rdata_q.
REQ-029 Latency: data_ok SHALL assert exactly 1+RESP_DELAY cycles after the handshake edge; peak throughput one transaction per 2+RESP_DELAY cycles with ADDR_DELAY=0.
REQ-030 Request fields SHALL be sampled only at the handshake; changes afterwards have no effect on the transaction.
REQ-031 Write data_ok SHALL follow the same timing as read; rdata content on a write response is don't-care.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, both counters=0, rdata_q=0; outputs addr_ok=0, data_ok=0, ram_en=0, ram_we=0000 during and after reset until a new handshake.
REQ-033 Reset mid-transaction (WAIT or RESP) SHALL drop it with no data_ok pulse; RAM writes already issued are not undone.
REQ-034 addr_ok SHALL be 0 in any cycle rst=1 regardless of req.

Verification
REQ-035 Defaults, RAM word 0x10 preloaded 0xDEADBEEF; read word addr 0x40, req held until addr_ok -> addr_ok same cycle as req, data_ok next cycle, rdata=0xDEADBEEF.
REQ-036 Byte write size=0 addr=0x43 wdata=0xAB000000 -> ram_we=1000, ram_addr=0x10; subsequent read of 0x40 returns 0xABADBEEF.
REQ-037 ADDR_DELAY=3, RESP_DELAY=2: req at cycle 0 -> addr_ok at cycle 3, data_ok at cycle 6 only, correct rdata; req dropped at cycle 2 then reasserted -> counter restarts.
REQ-038 Half write size=1 addr=0x46 -> ram_we=1100; size=3 addr=0x41 -> ram_we=1111, ram_addr=0x10.
REQ-039 rst asserted during WAIT (RESP_DELAY=4) -> no data_ok, state IDLE, next req accepted normally.
REQ-040 Back-to-back reads with req held continuously -> handshakes every 2 cycles, one data_ok per handshake, addr_ok never asserted while data_ok=1.

Source files
------------

// File: rtl/sram_like_slave_if.sv
// rtl/sram_like_slave_if.sv - request/response bus between a master and sram_like_slave
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - SRAM-like bus slave fronting a synchronous RAM
// One transaction outstanding; programmable accept and response delays.
module sram_like_slave #(
  parameter int ADDR_WIDTH = 14,
  parameter int ADDR_DELAY = 0,
  parameter int RESP_DELAY = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_like_slave_if.slave      bus,
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  dly_cnt_q, dly_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        first_q, first_d;
  logic [3:0]  we_mask;
  logic        handshake;
  logic        unused_addr;

  assign unused_addr = ^bus.addr;

  assign handshake   = !rst_i && (state_q == IDLE) && bus.req &&
                       (wait_cnt_q == 4'(ADDR_DELAY));
  assign bus.addr_ok = handshake;

  assign ram_addr_o  = bus.addr[ADDR_WIDTH+1:2];
  assign ram_wdata_o = bus.wdata;

  // With no response delay the RAM output is forwarded before it is registered.
  assign bus.rdata = (state_q == RESP && first_q) ? ram_rdata_i : rdata_q;

  always_comb begin
    case (bus.size)
      2'd0:    we_mask = 4'b0001 << bus.addr[1:0];
      2'd1:    we_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: we_mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    rdata_d     = rdata_q;
    first_d     = 1'b0;
    bus.data_ok = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;

    if (first_q) begin
      rdata_d = ram_rdata_i;
    end

    case (state_q)
      IDLE: begin
        if (handshake) begin
          wait_cnt_d = 4'd0;
          first_d    = 1'b1;
          ram_en_o   = 1'b1;
          ram_we_o   = bus.wr ? we_mask : 4'b0000;
          if (RESP_DELAY == 0) begin
            state_d = RESP;
          end else begin
            state_d   = WAIT;
            dly_cnt_d = 4'(RESP_DELAY);
          end
        end else if (!bus.req) begin
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < 4'(ADDR_DELAY)) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      WAIT: begin
        dly_cnt_d = dly_cnt_q - 4'd1;
        if (dly_cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.data_ok = !rst_i;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      dly_cnt_q  <= 4'd0;
      rdata_q    <= 32'd0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      rdata_q    <= rdata_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// tb/tb_sram_like_slave.sv - scoreboard bench for sram_like_slave in three delay configurations
module tb_sram_like_slave;
  localparam int NI = 3;
  localparam int AD [NI] = '{0, 3, 0};
  localparam int RD [NI] = '{0, 2, 4};

  typedef struct {
    int          inst;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb [$];

  logic        req_s [NI];
  logic        wr_s [NI];
  logic [1:0]  size_s [NI];
  logic [31:0] addr_s [NI];
  logic [31:0] wdata_s [NI];
  logic        addr_ok_w [NI];
  logic        data_ok_w [NI];
  logic [31:0] rdata_w [NI];
  logic        ram_en_w [NI];
  logic [3:0]  ram_we_w [NI];
  logic [13:0] ram_addr_w [NI];
  logic [31:0] ram_wdata_w [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_like_slave_if bus ();
    logic [31:0] mem [0:16383];
    logic [31:0] ram_rdata;

    assign bus.req      = req_s[g];
    assign bus.wr       = wr_s[g];
    assign bus.size     = size_s[g];
    assign bus.addr     = addr_s[g];
    assign bus.wdata    = wdata_s[g];
    assign addr_ok_w[g] = bus.addr_ok;
    assign data_ok_w[g] = bus.data_ok;
    assign rdata_w[g]   = bus.rdata;

    sram_like_slave #(
      .ADDR_WIDTH(14),
      .ADDR_DELAY(AD[g]),
      .RESP_DELAY(RD[g])
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus),
      .ram_en_o   (ram_en_w[g]),
      .ram_we_o   (ram_we_w[g]),
      .ram_addr_o (ram_addr_w[g]),
      .ram_wdata_o(ram_wdata_w[g]),
      .ram_rdata_i(ram_rdata)
    );

    always @(posedge clk) begin
      if (init) begin
        for (int i = 0; i < 16384; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'h0;
      end else if (ram_en_w[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_we_w[g][b]) mem[ram_addr_w[g]][8*b +: 8] <= ram_wdata_w[g][8*b +: 8];
        ram_rdata <= mem[ram_addr_w[g]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic txn(input int k, input bit w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] exp_we, input bit push,
                     input bit chk, input logic [31:0] exp_rd, input bit hold,
                     output int waited, output int hs_cyc);
    exp_t e;
    @(negedge clk);
    req_s[k] = 1'b1; wr_s[k] = w; size_s[k] = sz; addr_s[k] = a; wdata_s[k] = wd;
    waited = 0;
    #1;
    while (!addr_ok_w[k] && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    check("addr_ok", {31'd0, addr_ok_w[k]}, 32'd1);
    check("ram_en", {31'd0, ram_en_w[k]}, 32'd1);
    check("ram_we", {28'd0, ram_we_w[k]}, {28'd0, exp_we});
    check("ram_addr", {18'd0, ram_addr_w[k]}, {18'd0, a[15:2]});
    check("ram_wdata", ram_wdata_w[k], wd);
    hs_cyc = cyc;
    if (push) begin
      e.inst = k; e.chk = chk; e.data = exp_rd; e.cyc = cyc + 1 + RD[k];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) begin
      // Scramble the request fields: the accepted transaction must not notice.
      req_s[k] = 1'b0; wr_s[k] = ~w; size_s[k] = ~sz; addr_s[k] = ~a; wdata_s[k] = ~wd;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      for (int k = 0; k < NI; k++) begin
        if (data_ok_w[k]) begin
          check("addr_ok_in_resp", {31'd0, addr_ok_w[k]}, 32'd0);
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_data_ok: inst %0d pulsed at cycle %0d, none expected", k, cyc);
          end else begin
            e = sb.pop_front();
            check("resp_inst", k, e.inst);
            check("resp_cycle", cyc, e.cyc);
            if (e.chk) check("rdata", rdata_w[k], e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w, h1, h2;
    for (int k = 0; k < NI; k++) begin
      req_s[k] = 1'b1; wr_s[k] = 1'b0; size_s[k] = 2'd2; addr_s[k] = 32'h40; wdata_s[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    init = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_addr_ok", {31'd0, addr_ok_w[k]}, 32'd0);
      check("rst_data_ok", {31'd0, data_ok_w[k]}, 32'd0);
      check("rst_ram_en", {31'd0, ram_en_w[k]}, 32'd0);
      check("rst_ram_we", {28'd0, ram_we_w[k]}, 32'd0);
      check("rst_rdata_q", rdata_w[k], 32'd0);
      req_s[k] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;

    // Default configuration: read, lane writes, read-back, back-to-back.
    txn(0, 0, 2'd2, 32'h40, 32'h0, 4'b0000, 1, 1, 32'hDEADBEEF, 0, w, h1);
    check("d0_accept_wait", w, 32'd0);
    txn(0, 1, 2'd0, 32'h43, 32'hAB000000, 4'b1000, 1, 0, 32'h0, 0, w, h1);
    txn(0, 0, 2'd2, 32'h40, 32'h0, 4'b0000, 1, 1, 32'hABADBEEF, 0, w, h1);
    txn(0, 1, 2'd1, 32'h46, 32'h55660000, 4'b1100, 1, 0, 32'h0, 0, w, h1);
    txn(0, 1, 2'd0, 32'h45, 32'h00007700, 4'b0010, 1, 0, 32'h0, 0, w, h1);
    txn(0, 0, 2'd2, 32'h44, 32'h0, 4'b0000, 1, 1, 32'h55667700, 0, w, h1);
    txn(0, 1, 2'd3, 32'h41, 32'h01020304, 4'b1111, 1, 0, 32'h0, 0, w, h1);
    txn(0, 0, 2'd1, 32'h42, 32'h0, 4'b0000, 1, 1, 32'h01020304, 0, w, h1);
    drain();
    txn(0, 0, 2'd2, 32'h40, 32'h0, 4'b0000, 1, 1, 32'h01020304, 1, w, h1);
    txn(0, 0, 2'd2, 32'h44, 32'h0, 4'b0000, 1, 1, 32'h55667700, 1, w, h2);
    check("b2b_spacing_1", h2 - h1, 32'd2);
    txn(0, 0, 2'd2, 32'h40, 32'h0, 4'b0000, 1, 1, 32'h01020304, 0, w, h1);
    check("b2b_spacing_2", h1 - h2, 32'd2);
    drain();

    // ADDR_DELAY=3, RESP_DELAY=2: aborted request restarts the accept counter.
    @(negedge clk);
    req_s[1] = 1'b1; wr_s[1] = 1'b0; size_s[1] = 2'd2; addr_s[1] = 32'h40;
    #1 check("ad_hold0", {31'd0, addr_ok_w[1]}, 32'd0);
    @(negedge clk); #1 check("ad_hold1", {31'd0, addr_ok_w[1]}, 32'd0);
    @(negedge clk);
    req_s[1] = 1'b0;
    #1 check("ad_drop", {31'd0, addr_ok_w[1]}, 32'd0);
    txn(1, 0, 2'd2, 32'h40, 32'h0, 4'b0000, 1, 1, 32'hDEADBEEF, 0, w, h1);
    check("ad_restart_wait", w, 32'd3);
    drain();
    txn(1, 1, 2'd2, 32'h40, 32'hCAFEF00D, 4'b1111, 1, 0, 32'h0, 0, w, h1);
    check("ad_write_wait", w, 32'd3);
    drain();
    txn(1, 0, 2'd2, 32'h40, 32'h0, 4'b0000, 1, 1, 32'hCAFEF00D, 0, w, h1);
    drain();

    // RESP_DELAY=4: reset in WAIT drops the response but keeps the RAM write.
    txn(2, 1, 2'd2, 32'h80, 32'h12345678, 4'b1111, 0, 0, 32'h0, 0, w, h1);
    @(negedge clk);
    rst = 1'b1;
    req_s[2] = 1'b1;
    #1;
    check("mid_rst_addr_ok", {31'd0, addr_ok_w[2]}, 32'd0);
    check("mid_rst_data_ok", {31'd0, data_ok_w[2]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_s[2] = 1'b0;
    repeat (8) @(negedge clk);
    txn(2, 0, 2'd2, 32'h80, 32'h0, 4'b0000, 1, 1, 32'h12345678, 0, w, h1);
    check("post_rst_wait", w, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
